// File: rtl/rom_burst_arbiter.sv
// Two-requester round-robin burst sequencer in front of a single synchronous ROM.
// Issues one address per cycle and tags the returning words with the owning requester.
module rom_burst_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic [ADDR_W-1:0] start_addr0_i,
  input  logic [ADDR_W-1:0] start_addr1_i,
  input  logic [ADDR_W-1:0] len0_i,
  input  logic [ADDR_W-1:0] len1_i,
  output logic              ack0_o,
  output logic              ack1_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic              rom_enable_o,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic [DATA_W-1:0] data_out_o,
  output logic              valid0_o,
  output logic              valid1_o,
  output logic              last_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] ZERO_C = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ONE_C  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              rr_last_q, rr_last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] remain_q, remain_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic              valid0_q, valid0_d, valid1_q, valid1_d;
  logic              last_q, last_d;
  logic              grant1_s;

  // On a tie the requester that did not win last time is served.
  assign grant1_s = req1_i & (~req0_i | ~rr_last_q);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Burst bookkeeping and registered handshake/return-path flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q   <= 1'b0;
      rr_last_q <= 1'b1;
      addr_q    <= ZERO_C;
      remain_q  <= ZERO_C;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      valid0_q  <= 1'b0;
      valid1_q  <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      addr_q    <= addr_d;
      remain_q  <= remain_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      valid0_q  <= valid0_d;
      valid1_q  <= valid1_d;
      last_q    <= last_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    addr_d    = addr_q;
    remain_d  = remain_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    valid0_d  = (state_q == ISSUE) && (owner_q == 1'b0);
    valid1_d  = (state_q == ISSUE) && (owner_q == 1'b1);
    last_d    = (state_q == ISSUE) && (remain_q == ZERO_C);
    case (state_q)
      IDLE: begin
        if (req0_i || req1_i) begin
          owner_d   = grant1_s;
          rr_last_d = grant1_s;
          addr_d    = grant1_s ? start_addr1_i : start_addr0_i;
          remain_d  = grant1_s ? len1_i : len0_i;
          ack0_d    = ~grant1_s;
          ack1_d    = grant1_s;
          state_d   = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (remain_q == ZERO_C) begin
          state_d = DRAIN;
        end else begin
          addr_d   = addr_q + ONE_C;
          remain_d = remain_q - ONE_C;
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ROM drive and status outputs decoded from the current state.
  always_comb begin
    rom_enable_o = 1'b0;
    rom_addr_o   = ZERO_C;
    busy_o       = 1'b0;
    case (state_q)
      IDLE: begin
        busy_o = 1'b0;
      end
      ISSUE: begin
        rom_enable_o = 1'b1;
        rom_addr_o   = addr_q;
        busy_o       = 1'b1;
      end
      DRAIN: begin
        busy_o = 1'b1;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

  assign ack0_o     = ack0_q;
  assign ack1_o     = ack1_q;
  assign valid0_o   = valid0_q;
  assign valid1_o   = valid1_q;
  assign last_o     = last_q;
  assign data_out_o = rom_data_i;

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Directed plus randomized bench for rom_burst_arbiter; a per-cycle schedule of
// expected outputs is built from the burst timing rules as each request is accepted.
module tb_rom_burst_arbiter;

  localparam int MAXC = 1024;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [3:0] sa0, sa1, len0, len1;
  logic       ack0, ack1, rom_enable, valid0, valid1, last, busy;
  logic [3:0] rom_addr;
  logic [7:0] rom_data, data_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int m_free = 0;
  int m_rr = 1;

  bit       e_ack0[MAXC], e_ack1[MAXC], e_v0[MAXC], e_v1[MAXC];
  bit       e_last[MAXC], e_busy[MAXC], e_en[MAXC];
  bit [3:0] e_addr[MAXC];
  bit [7:0] e_data[MAXC];

  int cnt_en, cnt_v0, cnt_v1, cnt_last;
  bit rec_grants = 1'b0;
  int grants[$];

  rom_burst_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_i(req0), .req1_i(req1),
    .start_addr0_i(sa0), .start_addr1_i(sa1),
    .len0_i(len0), .len1_i(len1),
    .ack0_o(ack0), .ack1_o(ack1),
    .rom_addr_o(rom_addr), .rom_enable_o(rom_enable),
    .rom_data_i(rom_data), .data_out_o(data_out),
    .valid0_o(valid0), .valid1_o(valid1),
    .last_o(last), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Bench ROM: registered read, word[i] = A0 | i.
  always @(posedge clk) begin
    if (rom_enable) rom_data <= 8'hA0 | {4'h0, rom_addr};
  end

  // Reference model: on acceptance, lay out the whole burst on the cycle timeline.
  always @(posedge clk) begin
    int own, sa, n, a;
    cyc = cyc + 1;
    if (!rst_n) begin
      m_free = cyc + 1;
      m_rr   = 1;
    end else if (cyc >= m_free && (req0 || req1)) begin
      if (req0 && req1) own = 1 - m_rr;
      else              own = req1 ? 1 : 0;
      sa = (own == 1) ? int'(sa1) : int'(sa0);
      n  = ((own == 1) ? int'(len1) : int'(len0)) + 1;
      m_rr = own;
      if (cyc + n + 1 < MAXC) begin
        if (own == 1) e_ack1[cyc] = 1'b1; else e_ack0[cyc] = 1'b1;
        for (int k = 0; k < n; k++) begin
          a = (sa + k) % 16;
          e_en[cyc+k]   = 1'b1;
          e_addr[cyc+k] = 4'(a);
          e_busy[cyc+k] = 1'b1;
          if (own == 1) e_v1[cyc+k+1] = 1'b1; else e_v0[cyc+k+1] = 1'b1;
          e_data[cyc+k+1] = 8'hA0 | 8'(a);
        end
        e_busy[cyc+n] = 1'b1;
        e_last[cyc+n] = 1'b1;
      end
      m_free = cyc + n + 2;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic clr_cnt();
    cnt_en = 0; cnt_v0 = 0; cnt_v1 = 0; cnt_last = 0;
  endtask

  // One cycle: compare outputs with the schedule, then let requesters drop on ack.
  task automatic step();
    @(negedge clk);
    chk("ack0", 32'(ack0), 32'(e_ack0[cyc]));
    chk("ack1", 32'(ack1), 32'(e_ack1[cyc]));
    chk("valid0", 32'(valid0), 32'(e_v0[cyc]));
    chk("valid1", 32'(valid1), 32'(e_v1[cyc]));
    chk("last", 32'(last), 32'(e_last[cyc]));
    chk("busy", 32'(busy), 32'(e_busy[cyc]));
    chk("rom_enable", 32'(rom_enable), 32'(e_en[cyc]));
    if (e_en[cyc]) chk("rom_addr", 32'(rom_addr), 32'(e_addr[cyc]));
    if (e_v0[cyc] || e_v1[cyc]) chk("data_out", 32'(data_out), 32'(e_data[cyc]));
    cnt_en   += int'(rom_enable);
    cnt_v0   += int'(valid0);
    cnt_v1   += int'(valid1);
    cnt_last += int'(last);
    if (rec_grants && ack0 === 1'b1) grants.push_back(0);
    if (rec_grants && ack1 === 1'b1) grants.push_back(1);
    if (e_ack0[cyc]) req0 = 1'b0;
    if (e_ack1[cyc]) req1 = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    #1;
    for (int i = cyc; i < MAXC; i++) begin
      e_ack0[i] = 1'b0; e_ack1[i] = 1'b0; e_v0[i] = 1'b0; e_v1[i] = 1'b0;
      e_last[i] = 1'b0; e_busy[i] = 1'b0; e_en[i] = 1'b0;
    end
    chk("rst_ack0", 32'(ack0), 32'd0);
    chk("rst_ack1", 32'(ack1), 32'd0);
    chk("rst_valid0", 32'(valid0), 32'd0);
    chk("rst_valid1", 32'(valid1), 32'd0);
    chk("rst_last", 32'(last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rom_enable", 32'(rom_enable), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    steps(2);
    rst_n = 1'b1;
  endtask

  task automatic burst(input int who, input int sa, input int len);
    if (who == 1) begin req1 = 1'b1; sa1 = 4'(sa); len1 = 4'(len); end
    else          begin req0 = 1'b1; sa0 = 4'(sa); len0 = 4'(len); end
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    sa0 = 4'd0; sa1 = 4'd0; len0 = 4'd0; len1 = 4'd0;
    do_reset();

    // Single burst, then wrap-around burst on requester 1.
    clr_cnt(); burst(0, 2, 3); steps(8);
    chk("single_valid0_count", 32'(cnt_v0), 32'd4);
    chk("single_last_count", 32'(cnt_last), 32'd1);
    clr_cnt(); burst(1, 14, 3); steps(8);
    chk("wrap_valid1_count", 32'(cnt_v1), 32'd4);
    chk("wrap_valid0_count", 32'(cnt_v0), 32'd0);

    // Minimum and maximum lengths.
    clr_cnt(); burst(0, 9, 0); steps(5);
    chk("min_valid_count", 32'(cnt_v0), 32'd1);
    chk("min_last_count", 32'(cnt_last), 32'd1);
    clr_cnt(); burst(0, 5, 15); steps(20);
    chk("max_valid_count", 32'(cnt_v0), 32'd16);
    chk("max_enable_cycles", 32'(cnt_en), 32'd16);

    // Request arriving while busy waits for IDLE.
    clr_cnt(); burst(0, 0, 7); steps(3); burst(1, 9, 2); steps(18);
    chk("busy_valid1_count", 32'(cnt_v1), 32'd3);
    chk("busy_valid0_count", 32'(cnt_v0), 32'd8);

    // Tie arbitration from reset: expect grants 0,1,0,1.
    do_reset();
    grants.delete(); rec_grants = 1'b1;
    burst(0, 1, 0); burst(1, 2, 0); steps(10);
    burst(0, 3, 0); burst(1, 4, 0); steps(10);
    rec_grants = 1'b0;
    chk("tie_grant_count", 32'(grants.size()), 32'd4);
    for (int i = 0; i < grants.size() && i < 4; i++)
      chk("tie_grant_order", 32'(grants[i]), 32'(i % 2));

    // Reset in the third cycle of a len=7 burst, then a fresh short burst.
    clr_cnt(); burst(0, 0, 7); steps(3);
    do_reset();
    clr_cnt(); steps(3);
    chk("post_reset_no_valid", 32'(cnt_v0 + cnt_v1), 32'd0);
    clr_cnt(); burst(0, 0, 1); steps(6);
    chk("post_reset_burst_valids", 32'(cnt_v0), 32'd2);

    // Randomized traffic; start/len may also change while a request is pending.
    for (int i = 0; i < 500; i++) begin
      step();
      if (!req0 && !e_ack0[cyc] && $urandom_range(0, 3) == 0) burst(0, $urandom_range(0, 15), $urandom_range(0, 15));
      else if ($urandom_range(0, 7) == 0) begin sa0 = 4'($urandom_range(0, 15)); len0 = 4'($urandom_range(0, 15)); end
      if (!req1 && !e_ack1[cyc] && $urandom_range(0, 3) == 0) burst(1, $urandom_range(0, 15), $urandom_range(0, 15));
      else if ($urandom_range(0, 7) == 0) begin sa1 = 4'($urandom_range(0, 15)); len1 = 4'($urandom_range(0, 15)); end
    end
    steps(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
